// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the async FIFO write-port arbiter.
// The arbiter uses the slave modport; whoever drives requests and the read pointer uses master.
interface fifo_wr_arbiter_if #(
  parameter int unsigned ADDRSIZE = 4,
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned NREQ     = 4
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*DSIZE-1:0] wdata_in;
  logic [ADDRSIZE:0]     wq2_rptr;
  logic [NREQ-1:0]       gnt;
  logic                  winc;
  logic [ADDRSIZE-1:0]   waddr;
  logic [DSIZE-1:0]      wdata;
  logic [ADDRSIZE:0]     wptr;
  logic                  wfull;
  logic [OW-1:0]         owner;
  logic                  locked;

  modport slave (
    input  req, lock, wdata_in, wq2_rptr,
    output gnt, winc, waddr, wdata, wptr, wfull, owner, locked
  );

  modport master (
    output req, lock, wdata_in, wq2_rptr,
    input  gnt, winc, waddr, wdata, wptr, wfull, owner, locked
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Write side of the async FIFO: round-robin arbitration with bounded burst lock,
// write pointer (binary + Gray) ownership and registered full generation.
module fifo_wr_arbiter #(
  parameter int unsigned ADDRSIZE = 4,
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAXBURST = 4
) (
  input logic               wclk,
  input logic               wrst,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [OW-1:0] LastIdx = OW'(NREQ - 1);
  localparam logic [3:0] BurstMax = 4'(MAXBURST);

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e            state_q;
  logic [OW-1:0]     owner_q;
  logic [OW-1:0]     rr_ptr_q;
  logic [3:0]        burst_cnt_q;
  logic [ADDRSIZE:0] wbin_q;
  logic [ADDRSIZE:0] wptr_q;
  logic              wfull_q;

  logic              gnt_any;
  logic [OW-1:0]     gnt_idx;
  logic [NREQ-1:0]   gnt;
  logic [DSIZE-1:0]  wdata_mux;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgnext;
  logic [ADDRSIZE:0] rptr_full_pat;
  logic              full_next;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
    if (i == LastIdx) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // Grant is held off during reset so a reset-time request never reaches memory.
  always_comb begin
    int s;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    s       = 0;
    if (!wrst && !wfull_q) begin
      if (state_q == StLock) begin
        if (bus.req[owner_q]) begin
          gnt_any = 1'b1;
          gnt_idx = owner_q;
        end
      end else begin
        for (int k = 0; k < int'(NREQ); k++) begin
          s = int'(rr_ptr_q) + k;
          if (s >= int'(NREQ)) begin
            s = s - int'(NREQ);
          end
          if (!gnt_any && bus.req[s]) begin
            gnt_any = 1'b1;
            gnt_idx = OW'(s);
          end
        end
      end
      if (gnt_any) begin
        gnt[gnt_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    wdata_mux = '0;
    if (gnt_any) begin
      wdata_mux = bus.wdata_in[gnt_idx*DSIZE +: DSIZE];
    end
  end

  // Full when the next Gray write pointer equals the read pointer with its top two bits inverted.
  assign wbin_next     = wbin_q + {{ADDRSIZE{1'b0}}, gnt_any};
  assign wgnext        = (wbin_next >> 1) ^ wbin_next;
  assign rptr_full_pat = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};
  assign full_next     = (wgnext == rptr_full_pat);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q     <= StArb;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      wbin_q      <= '0;
      wptr_q      <= '0;
      wfull_q     <= 1'b0;
    end else begin
      wbin_q  <= wbin_next;
      wptr_q  <= wgnext;
      wfull_q <= full_next;
      unique case (state_q)
        StArb: begin
          if (gnt_any) begin
            if (MAXBURST > 1 && bus.lock[gnt_idx]) begin
              state_q     <= StLock;
              owner_q     <= gnt_idx;
              burst_cnt_q <= 4'd1;
            end else begin
              rr_ptr_q <= next_idx(gnt_idx);
            end
          end
        end
        StLock: begin
          if (!bus.req[owner_q]) begin
            state_q     <= StArb;
            rr_ptr_q    <= next_idx(owner_q);
            burst_cnt_q <= '0;
          end else if (gnt_any) begin
            if (!bus.lock[owner_q] || (burst_cnt_q + 4'd1 == BurstMax)) begin
              state_q     <= StArb;
              rr_ptr_q    <= next_idx(owner_q);
              burst_cnt_q <= '0;
            end else begin
              burst_cnt_q <= burst_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  assign bus.gnt    = gnt;
  assign bus.winc   = gnt_any;
  assign bus.waddr  = wbin_q[ADDRSIZE-1:0];
  assign bus.wdata  = wdata_mux;
  assign bus.wptr   = wptr_q;
  assign bus.wfull  = wfull_q;
  assign bus.owner  = owner_q;
  assign bus.locked = (state_q == StLock);

  a_gnt_onehot: assert property (@(posedge wclk) disable iff (wrst) $onehot0(gnt));
  a_no_write_full: assert property (@(posedge wclk) disable iff (wrst) !(gnt_any && wfull_q));
  a_burst_bound: assert property (@(posedge wclk) disable iff (wrst) burst_cnt_q < BurstMax);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a per-cycle transaction model.
module tb_fifo_wr_arbiter;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned NR   = 4;
  localparam int unsigned MAXB = 4;
  localparam int          PMOD = 1 << (AW + 1);
  localparam int          DEPTH = 1 << AW;

  logic wclk;
  logic wrst;

  fifo_wr_arbiter_if #(.ADDRSIZE(AW), .DSIZE(DW), .NREQ(NR)) bus ();

  fifo_wr_arbiter #(.ADDRSIZE(AW), .DSIZE(DW), .NREQ(NR), .MAXBURST(MAXB)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: write count, read count, ownership and burst progress as plain integers.
  int m_wbin, m_rd, m_rr, m_owner, m_cnt;
  bit m_full;
  int last_g;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW:0] gray(input int x);
    logic [AW:0] b;
    b = AW'(x) | ((x & (1 << AW)) != 0 ? (AW+1)'(1 << AW) : '0);
    return (b >> 1) ^ b;
  endfunction

  function automatic int exp_grant();
    int idx;
    if (m_full) return -1;
    if (m_owner >= 0) return bus.req[m_owner] ? m_owner : -1;
    for (int k = 0; k < int'(NR); k++) begin
      idx = (m_rr + k) % int'(NR);
      if (bus.req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_wbin = 0; m_rd = 0; m_rr = 0; m_owner = -1; m_cnt = 0; m_full = 0;
  endtask

  task automatic run_cycle();
    int g;
    logic [DW-1:0] exp_d;
    bus.wdata_in = $urandom;
    bus.wq2_rptr = gray(m_rd);
    @(negedge wclk);
    g = exp_grant();
    exp_d = (g >= 0) ? bus.wdata_in[g*DW +: DW] : '0;
    check_eq("gnt",   32'(bus.gnt),   (g >= 0) ? (32'd1 << g) : 32'd0);
    check_eq("winc",  32'(bus.winc),  32'(g >= 0));
    check_eq("wdata", 32'(bus.wdata), 32'(exp_d));
    check_eq("waddr", 32'(bus.waddr), 32'(m_wbin % DEPTH));
    check_eq("wptr",  32'(bus.wptr),  32'(gray(m_wbin)));
    check_eq("wfull", 32'(bus.wfull), 32'(m_full));
    check_eq("locked", 32'(bus.locked), 32'(m_owner >= 0));
    if (m_owner >= 0) check_eq("owner", 32'(bus.owner), 32'(m_owner));
    last_g = g;
    @(posedge wclk);
    if (g >= 0) m_wbin = (m_wbin + 1) % PMOD;
    if (m_owner < 0) begin
      if (g >= 0) begin
        if (MAXB > 1 && bus.lock[g]) begin
          m_owner = g; m_cnt = 1;
        end else begin
          m_rr = (g + 1) % int'(NR);
        end
      end
    end else if (!bus.req[m_owner]) begin
      m_rr = (m_owner + 1) % int'(NR); m_owner = -1; m_cnt = 0;
    end else if (g >= 0) begin
      m_cnt++;
      if (!bus.lock[m_owner] || m_cnt == int'(MAXB)) begin
        m_rr = (m_owner + 1) % int'(NR); m_owner = -1; m_cnt = 0;
      end
    end
    m_full = (((m_wbin - m_rd) % PMOD + PMOD) % PMOD) == DEPTH;
    #1;
  endtask

  // Entered at posedge+1; asserts reset mid-cycle and checks the asynchronous clear.
  task automatic do_reset();
    wrst = 1'b1;
    bus.req = '1;
    #2;
    check_eq("rst_gnt",    32'(bus.gnt),    32'd0);
    check_eq("rst_winc",   32'(bus.winc),   32'd0);
    check_eq("rst_wptr",   32'(bus.wptr),   32'd0);
    check_eq("rst_wfull",  32'(bus.wfull),  32'd0);
    check_eq("rst_locked", 32'(bus.locked), 32'd0);
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    model_reset();
    bus.wq2_rptr = '0;
  endtask

  initial begin
    int fair_exp[14];
    wrst = 1'b1;
    bus.req = '1;
    bus.lock = '0;
    bus.wdata_in = '0;
    bus.wq2_rptr = '0;
    model_reset();
    fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0, 2, 3};

    do_reset();
    run_cycle();
    check_eq("first_gnt", 32'(last_g), 32'd0);

    // Fill by requester 2 with the read pointer parked at 0.
    do_reset();
    bus.req = 4'b0100; bus.lock = '0;
    for (int i = 0; i < DEPTH; i++) begin
      run_cycle();
      check_eq("fill_gnt", 32'(last_g), 32'd2);
    end
    check_eq("fill_wfull", 32'(bus.wfull), 32'd1);
    check_eq("fill_wptr",  32'(bus.wptr),  32'b11000);
    repeat (3) run_cycle();
    check_eq("fill_stall", 32'(last_g), 32'hFFFF_FFFF);

    // Fairness with the reader keeping up.
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 14; i++) begin
      if (i == 8) bus.req = 4'b1101;
      m_rd = m_wbin;
      run_cycle();
      check_eq("fair_seq", 32'(last_g), 32'(fair_exp[i]));
    end

    // Burst by requester 1 starting with rr pointing at it.
    do_reset();
    bus.req = 4'b0001;
    run_cycle();
    bus.req = 4'b1111; bus.lock = 4'b0010;
    for (int i = 0; i < int'(MAXB); i++) begin
      m_rd = m_wbin;
      run_cycle();
      check_eq("burst_gnt", 32'(last_g), 32'd1);
    end
    check_eq("burst_end", 32'(bus.locked), 32'd0);
    run_cycle();
    check_eq("burst_next", 32'(last_g), 32'd2);

    // Full reached inside a lock owned by requester 3, then drained one slot at a time.
    do_reset();
    bus.req = 4'b1000; bus.lock = '0;
    repeat (DEPTH - 2) run_cycle();
    bus.lock = 4'b1000;
    repeat (2) run_cycle();
    check_eq("lockfull_wfull", 32'(bus.wfull), 32'd1);
    check_eq("lockfull_owner", 32'(bus.owner), 32'd3);
    repeat (2) run_cycle();
    m_rd = 1;
    run_cycle();
    check_eq("lockfull_drop", 32'(bus.wfull), 32'd0);
    run_cycle();
    check_eq("lockfull_resume", 32'(last_g), 32'd3);
    check_eq("lockfull_held", 32'(bus.locked), 32'd1);
    m_rd = 2;
    repeat (2) run_cycle();
    check_eq("lockfull_exit", 32'(bus.locked), 32'd0);

    // Reset while requester 2 holds a lock with two writes done.
    do_reset();
    bus.req = 4'b0100; bus.lock = 4'b0100;
    repeat (2) run_cycle();
    check_eq("mid_locked", 32'(bus.locked), 32'd1);
    do_reset();
    bus.lock = '0;
    run_cycle();
    check_eq("mid_first", 32'(last_g), 32'd0);

    // Random traffic with a randomly lagging reader.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.req  = NR'($urandom);
      bus.lock = NR'($urandom & $urandom);
      if ($urandom_range(0, 2) != 0 && m_rd != m_wbin) m_rd = (m_rd + 1) % PMOD;
      if (i == 1500) do_reset();
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side controller for the async FIFO. It shares the single FIFO write port between NREQ requesters using round-robin arbitration, with an optional bounded burst lock. It owns the write pointer (binary and Gray) and generates wfull from the read pointer after that pointer has been synchronized into the write domain. The block sits entirely in the wclk domain, between the requesters and the FIFO memory write port.

Parameters:
ADDRSIZE, 4, FIFO address width; depth = 2**ADDRSIZE.
DSIZE, 8, data width per requester.
NREQ, 4, number of requesters (2..8).
MAXBURST, 4, maximum consecutive locked writes by one requester (1..15).

Ports:
wclk  input  1  write-domain clock.
wrst  input  1  asynchronous, active-high reset.
req  input  NREQ  per-requester write request.
lock  input  NREQ  per-requester burst-lock request; meaningful only together with req.
wdata_in  input  NREQ*DSIZE  requester data; requester i occupies bits [i*DSIZE +: DSIZE].
wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronized into wclk.
gnt  output  NREQ  one-hot grant; combinational; gnt[i]=1 means requester i's data is written at this clock edge.
winc  output  1  write enable to memory; equals OR of gnt.
waddr  output  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0].
wdata  output  DSIZE  wdata_in slice of the granted requester; 0 when no grant.
wptr  output  ADDRSIZE+1  registered Gray write pointer, to the write-to-read synchronizer.
wfull  output  1  registered full flag.
owner  output  clog2(NREQ)  index of the current lock owner; valid when locked=1.
locked  output  1  a burst lock is active.

Behaviour:
- Reset (async, wrst=1): wbin=0, wptr=0, wfull=0, rr_ptr=0 (requester 0 highest priority), locked=0, owner=0, burst_cnt=0. Combinational outputs gnt, winc and wdata are 0 whenever wfull=1 or no req is high.
- State machine, two states:
  - ARB (locked=0): if wfull=0 and any req is high, grant the first requester with req high, searching from rr_ptr upward modulo NREQ.
    - Granted requester i with lock[i]=0 and MAXBURST>1: next rr_ptr = (i+1) mod NREQ; stay in ARB.
    - Granted requester i with lock[i]=1 and MAXBURST>1: go to LOCK; owner=i; burst_cnt=1; rr_ptr unchanged.
    - MAXBURST=1: never enter LOCK; lock is ignored.
  - LOCK (locked=1): only the owner can be granted. gnt[owner] = req[owner] & ~wfull. Each granted write increments burst_cnt.
    - Exit to ARB with rr_ptr = (owner+1) mod NREQ on the first of:
      - a granted write while lock[owner]=0 (that write completes the burst);
      - a granted write that makes burst_cnt reach MAXBURST;
      - req[owner]=0 (no write that cycle; the other requesters wait one cycle).
    - While wfull=1 in LOCK: no grant, burst_cnt held, ownership retained.
- Write latency:
  - winc is asserted in the same cycle as gnt.
  - At that clock edge: wbin <= wbin+1 and wptr <= gray(wbin+1), where gray(x) = (x>>1)^x.
  - waddr reflects the new wbin in the following cycle.
- Full:
  - wgnext = gray(wbin + winc).
  - wfull <= (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull therefore rises on the edge of the write that fills the FIFO, and falls one cycle after wq2_rptr advances.
  - A write is never issued while wfull=1.
- Wrap-around: wbin wraps modulo 2**(ADDRSIZE+1) with no special handling; the Gray MSB-pair compare handles the wrap.
- Simultaneous req/lock changes: sampled only in the grant cycle. lock from a non-owner during LOCK is ignored.
- Reset mid-burst: lock state, pointers and burst count are cleared immediately. The first post-reset grant follows ARB rules from requester 0.

Test Plan:
- Reset: wrst=1 with req=4'b1111 -> gnt=0, winc=0, wptr=0, wfull=0, locked=0. After release with wq2_rptr=0, gnt=4'b0001 in the first cycle.
- Fill: only req[2]=1, lock=0, wq2_rptr held at 0 -> 16 consecutive grants, waddr 0..15, wfull=1 after the 16th edge, wptr=5'b11000, gnt=0 thereafter.
- Fairness: req=4'b1111, lock=0, FIFO never full -> grant sequence 0,1,2,3,0,1,... Drop req[1] -> sequence 0,2,3,0,...
- Burst: req=4'b1111, lock[1]=1 held, MAXBURST=4, rr_ptr at 1 -> four consecutive gnt=4'b0010, then locked=0 and the next grant goes to requester 2.
- Full/drain boundary: fill to wfull=1 mid-LOCK (owner 3), then step wq2_rptr Gray 0->1 -> wfull=0 one cycle later, owner 3 resumes, burst_cnt continues from its held value.
- Reset mid-burst: wrst pulsed while locked=1, owner=2, burst_cnt=2 -> locked=0, wptr=0, wfull=0 asynchronously; next grant goes to requester 0 if it is requesting.
